// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors blocks: result codes, match
// states, and the digit helpers used by the score display.
package rps_pkg;

  localparam logic [1:0] RES_WIN     = 2'd0;
  localparam logic [1:0] RES_LOSE    = 2'd1;
  localparam logic [1:0] RES_TIE     = 2'd2;
  localparam logic [1:0] RES_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_PLAYING    = 2'b01,
    ST_MATCH_OVER = 2'b10
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SCORE_MAX = 7'd99;

  // Active-low {dp,g,f,e,d,c,b,a}; anything that is not a decimal digit is dark.
  function automatic logic [7:0] seg_lut(input logic [3:0] code);
    logic [7:0] s;
    case (code)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v >= SCORE_MAX) ? SCORE_MAX : v + 7'd1;
  endfunction

  function automatic logic [3:0] tens_of(input logic [6:0] v);
    logic [3:0] t;
    t = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if (v >= 7'(k * 10)) t = 4'(k);
    end
    return t;
  endfunction

  function automatic logic [3:0] ones_of(input logic [6:0] v);
    return 4'(v - 7'(tens_of(v)) * 7'd10);
  endfunction

endpackage

// File: rtl/rps_score_tracker_if.sv
// Result handshake from the round engine into the score tracker.
interface rps_score_tracker_if;
  logic       result_valid;
  logic [1:0] result_code;
  logic       new_match;

  modport master (output result_valid, output result_code, output new_match);
  modport slave  (input  result_valid, input  result_code, input  new_match);
endinterface

// File: rtl/seg7_scanner.sv
// Four-digit multiplexed seven-segment driver: rotates digits 3..0, one slot
// per SCAN_DELAY cycles, with registered segment and digit-enable outputs.
module seg7_scanner
  import rps_pkg::*;
#(
  parameter int SCAN_DELAY = 2500
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [3:0][3:0] digits,
  input  logic [3:0]      blank,
  output logic [7:0]      seg,
  output logic [3:0]      digit_sel
);

  localparam int CW = (SCAN_DELAY > 1) ? $clog2(SCAN_DELAY) : 1;

  logic [CW-1:0] scan_cnt_reg;
  logic [1:0]    idx_reg;
  logic [7:0]    glyph [4];
  logic          advance;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_glyph
      assign glyph[gi] = blank[gi] ? SEG_BLANK : seg_lut(digits[gi]);
    end
  endgenerate

  assign advance = (scan_cnt_reg == CW'(SCAN_DELAY - 1));

  // Segments and enable are captured together so a slot never shows a
  // neighbour's glyph.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_reg <= '0;
      idx_reg      <= 2'd3;
      seg          <= SEG_BLANK;
      digit_sel    <= 4'b1111;
    end else if (advance) begin
      scan_cnt_reg <= '0;
      idx_reg      <= idx_reg - 2'd1;
      seg          <= glyph[idx_reg];
      digit_sel    <= ~(4'b0001 << idx_reg);
    end else begin
      scan_cnt_reg <= scan_cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/rps_score_tracker.sv
// Match scorekeeper for the rock-paper-scissors game: turns round results into
// tallies, declares a first-to-WIN_TARGET champion and drives the score display.
module rps_score_tracker
  import rps_pkg::*;
#(
  parameter int WIN_TARGET = 3,
  parameter int SCAN_DELAY = 2500,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic               clk,
  input  logic               reset_n,
  rps_score_tracker_if.slave eng,
  output logic [6:0]         score_player,
  output logic [6:0]         score_cpu,
  output logic [6:0]         ties,
  output logic               match_over,
  output logic               player_champion,
  output logic               cpu_champion,
  output logic               code_err,
  output logic [7:0]         seg,
  output logic [3:0]         digit_sel
);

  localparam int BW = $clog2(BLINK_DIV + 1);

  state_t        state_reg, state_next;
  logic [6:0]    player_reg, player_next;
  logic [6:0]    cpu_reg, cpu_next;
  logic [6:0]    ties_reg, ties_next;
  logic          err_reg, err_next;
  logic          pchamp_reg, pchamp_next;
  logic          cchamp_reg, cchamp_next;
  logic          valid_q_reg, new_q_reg;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          blink_show_reg, blink_show_next;

  logic          result_evt, new_evt;
  logic [6:0]    player_inc, cpu_inc;

  assign result_evt = eng.result_valid & ~valid_q_reg;
  assign new_evt    = eng.new_match & ~new_q_reg;
  assign player_inc = sat_inc(player_reg);
  assign cpu_inc    = sat_inc(cpu_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_PLAYING;
      player_reg     <= '0;
      cpu_reg        <= '0;
      ties_reg       <= '0;
      err_reg        <= 1'b0;
      pchamp_reg     <= 1'b0;
      cchamp_reg     <= 1'b0;
      valid_q_reg    <= 1'b0;
      new_q_reg      <= 1'b0;
      blink_cnt_reg  <= '0;
      blink_show_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      player_reg     <= player_next;
      cpu_reg        <= cpu_next;
      ties_reg       <= ties_next;
      err_reg        <= err_next;
      pchamp_reg     <= pchamp_next;
      cchamp_reg     <= cchamp_next;
      valid_q_reg    <= eng.result_valid;
      new_q_reg      <= eng.new_match;
      blink_cnt_reg  <= blink_cnt_next;
      blink_show_reg <= blink_show_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    player_next     = player_reg;
    cpu_next        = cpu_reg;
    ties_next       = ties_reg;
    err_next        = err_reg;
    pchamp_next     = pchamp_reg;
    cchamp_next     = cchamp_reg;
    blink_cnt_next  = '0;
    blink_show_next = 1'b1;

    // A new match request takes priority and swallows a coincident result.
    if (new_evt) begin
      state_next  = ST_PLAYING;
      player_next = '0;
      cpu_next    = '0;
      ties_next   = '0;
      err_next    = 1'b0;
      pchamp_next = 1'b0;
      cchamp_next = 1'b0;
    end else begin
      case (state_reg)
        ST_PLAYING: begin
          if (result_evt) begin
            case (eng.result_code)
              RES_WIN: begin
                player_next = player_inc;
                if (player_inc == 7'(WIN_TARGET)) begin
                  state_next  = ST_MATCH_OVER;
                  pchamp_next = 1'b1;
                end
              end
              RES_LOSE: begin
                cpu_next = cpu_inc;
                if (cpu_inc == 7'(WIN_TARGET)) begin
                  state_next  = ST_MATCH_OVER;
                  cchamp_next = 1'b1;
                end
              end
              RES_TIE: ties_next = sat_inc(ties_reg);
              default: err_next = 1'b1;
            endcase
          end
        end
        ST_MATCH_OVER: begin
          if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
            blink_show_next = ~blink_show_reg;
          end else begin
            blink_cnt_next  = blink_cnt_reg + BW'(1);
            blink_show_next = blink_show_reg;
          end
        end
        default: state_next = ST_PLAYING;
      endcase
    end
  end

  assign score_player    = player_reg;
  assign score_cpu       = cpu_reg;
  assign ties            = ties_reg;
  assign code_err        = err_reg;
  assign match_over      = (state_reg == ST_MATCH_OVER);
  assign player_champion = pchamp_reg & match_over;
  assign cpu_champion    = cchamp_reg & match_over;

  logic [3:0][3:0] digits;
  logic [3:0]      blank;
  logic            blink_dark;

  assign digits     = {tens_of(player_reg), ones_of(player_reg),
                       tens_of(cpu_reg), ones_of(cpu_reg)};
  assign blink_dark = ~blink_show_reg;
  assign blank[3]   = (digits[3] == 4'd0) | (blink_dark & player_champion);
  assign blank[2]   = blink_dark & player_champion;
  assign blank[1]   = (digits[1] == 4'd0) | (blink_dark & cpu_champion);
  assign blank[0]   = blink_dark & cpu_champion;

  seg7_scanner #(
    .SCAN_DELAY (SCAN_DELAY)
  ) u_scanner (
    .clk       (clk),
    .reset_n   (reset_n),
    .digits    (digits),
    .blank     (blank),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

endmodule

// File: tb/tb_rps_score_tracker.sv
// Directed bench for rps_score_tracker: scoring, match end, priority, display
// scan, blink and asynchronous reset.
module tb_rps_score_tracker;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  rps_score_tracker_if eng1();
  rps_score_tracker_if eng2();

  logic [6:0] sp1, sc1, t1, sp2, sc2, t2;
  logic       mo1, pc1, cc1, err1, mo2, pc2, cc2, err2;
  logic [7:0] seg1, seg2;
  logic [3:0] ds1, ds2;

  rps_score_tracker #(.WIN_TARGET(3), .SCAN_DELAY(4), .BLINK_DIV(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .eng(eng1.slave),
    .score_player(sp1), .score_cpu(sc1), .ties(t1), .match_over(mo1),
    .player_champion(pc1), .cpu_champion(cc1), .code_err(err1),
    .seg(seg1), .digit_sel(ds1)
  );

  // Second instance with a higher target so two-digit scores can be displayed.
  rps_score_tracker #(.WIN_TARGET(20), .SCAN_DELAY(4), .BLINK_DIV(16)) u_dut_disp (
    .clk(clk), .reset_n(reset_n), .eng(eng2.slave),
    .score_player(sp2), .score_cpu(sc2), .ties(t2), .match_over(mo2),
    .player_champion(pc2), .cpu_champion(cc2), .code_err(err2),
    .seg(seg2), .digit_sel(ds2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drops valid, then raises it with a new code; returns just after the edge
  // on which the event is taken, with valid still held.
  task automatic send(input bit which, input logic [1:0] code);
    @(negedge clk);
    if (which) eng2.result_valid = 1'b0; else eng1.result_valid = 1'b0;
    @(negedge clk);
    if (which) begin
      eng2.result_code = code; eng2.result_valid = 1'b1;
    end else begin
      eng1.result_code = code; eng1.result_valid = 1'b1;
    end
    @(posedge clk); #1;
    if (which)
      $display("send dut%0d code=%0d player=%0d cpu=%0d ties=%0d", which, code, sp2, sc2, t2);
    else
      $display("send dut%0d code=%0d player=%0d cpu=%0d ties=%0d", which, code, sp1, sc1, t1);
  endtask

  task automatic start_match();
    @(negedge clk); eng1.new_match = 1'b1;
    @(posedge clk); #1;
    $display("new_match player=%0d cpu=%0d ties=%0d", sp1, sc1, t1);
    @(negedge clk); eng1.new_match = 1'b0;
  endtask

  logic [3:0] prev;
  logic [7:0] d0 [3];
  logic [7:0] d2 [3];
  logic [7:0] exp_seg [4];
  logic [3:0] exp_sel [4];
  int n0, n2, len;
  bit synced;

  initial begin
    eng1.result_valid = 1'b0; eng1.result_code = 2'd0; eng1.new_match = 1'b0;
    eng2.result_valid = 1'b0; eng2.result_code = 2'd0; eng2.new_match = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_player", sp1, 0);
    check("rst_cpu", sc1, 0);
    check("rst_ties", t1, 0);
    check("rst_match_over", mo1, 0);
    check("rst_code_err", err1, 0);
    check("rst_seg", seg1, 8'hFF);
    check("rst_digit_sel", ds1, 4'b1111);
    @(negedge clk); reset_n = 1'b1;

    // Held level counts once.
    @(negedge clk); eng1.result_code = 2'd0; eng1.result_valid = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    $display("held code=0 for 50 cycles player=%0d", sp1);
    check("held_player", sp1, 1);
    check("held_cpu", sc1, 0);
    check("held_ties", t1, 0);

    send(0, 2'd0);
    check("win2_match_over", mo1, 0);
    send(0, 2'd0);
    check("win3_player", sp1, 3);
    check("win3_match_over", mo1, 1);
    check("win3_player_champ", pc1, 1);
    check("win3_cpu_champ", cc1, 0);
    send(0, 2'd0);
    check("frozen_player", sp1, 3);
    send(0, 2'd1);
    check("frozen_cpu", sc1, 0);

    start_match();
    check("clear_player", sp1, 0);
    check("clear_match_over", mo1, 0);
    check("clear_player_champ", pc1, 0);

    send(0, 2'd1); send(0, 2'd2); send(0, 2'd2); send(0, 2'd3); send(0, 2'd1);
    check("mix_cpu", sc1, 2);
    check("mix_ties", t1, 2);
    check("mix_code_err", err1, 1);
    check("mix_match_over", mo1, 0);
    check("mix_player", sp1, 0);

    // New match and a result that would have ended the match, same cycle.
    @(negedge clk); eng1.result_valid = 1'b0;
    @(negedge clk); eng1.result_code = 2'd1; eng1.result_valid = 1'b1; eng1.new_match = 1'b1;
    @(posedge clk); #1;
    $display("simultaneous new_match+code1 player=%0d cpu=%0d ties=%0d", sp1, sc1, t1);
    check("sim_cpu", sc1, 0);
    check("sim_ties", t1, 0);
    check("sim_code_err", err1, 0);
    check("sim_match_over", mo1, 0);
    check("sim_cpu_champ", cc1, 0);
    @(negedge clk); eng1.new_match = 1'b0;

    // Computer takes the match 3-1, then watch its pair blink.
    send(0, 2'd0);
    send(0, 2'd1); send(0, 2'd1); send(0, 2'd1);
    check("cpu_win_match_over", mo1, 1);
    check("cpu_win_cpu_champ", cc1, 1);
    check("cpu_win_player_champ", pc1, 0);
    n0 = 0; n2 = 0; prev = ds1;
    for (int c = 0; c < 80 && (n0 < 3 || n2 < 3); c++) begin
      @(posedge clk); #1;
      if (ds1 != prev) begin
        if (ds1 == 4'b1110 && n0 < 3) begin d0[n0] = seg1; n0++; end
        if (ds1 == 4'b1011 && n2 < 3) begin d2[n2] = seg1; n2++; end
      end
      prev = ds1;
    end
    check("blink_d0_slots", n0, 3);
    check("blink_d2_slots", n2, 3);
    check("blink_d0_first", d0[0], 8'hB0);
    check("blink_d0_dark", d0[1], 8'hFF);
    check("blink_d0_back", d0[2], 8'hB0);
    for (int i = 0; i < 3; i++) check("steady_d2", d2[i], 8'hF9);

    // Display content and slot timing on the 12:5 instance.
    for (int i = 0; i < 12; i++) send(1, 2'd0);
    for (int i = 0; i < 5; i++) send(1, 2'd1);
    check("disp_player", sp2, 12);
    check("disp_cpu", sc2, 5);
    exp_sel[0] = 4'b0111; exp_seg[0] = 8'hF9;
    exp_sel[1] = 4'b1011; exp_seg[1] = 8'hA4;
    exp_sel[2] = 4'b1101; exp_seg[2] = 8'hFF;
    exp_sel[3] = 4'b1110; exp_seg[3] = 8'h92;
    synced = 1'b0; prev = ds2;
    for (int c = 0; c < 40 && !synced; c++) begin
      @(posedge clk); #1;
      if (ds2 != prev && ds2 == 4'b0111) synced = 1'b1;
      prev = ds2;
    end
    check("disp_sync", synced, 1);
    for (int s = 0; s < 4; s++) begin
      check("disp_sel", ds2, exp_sel[s]);
      check("disp_seg", seg2, exp_seg[s]);
      $display("slot %0d digit_sel=%b seg=%h", s, ds2, seg2);
      len = 1; prev = ds2;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        if (ds2 != prev) break;
        len++;
      end
      check("disp_slot_len", len, 4);
    end

    // Asynchronous reset lands between clock edges.
    check("pre_reset_scanning", ds1 != 4'b1111, 1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    $display("async reset applied seg=%h digit_sel=%b", seg1, ds1);
    check("arst_seg", seg1, 8'hFF);
    check("arst_digit_sel", ds1, 4'b1111);
    check("arst_cpu", sc1, 0);
    check("arst_match_over", mo1, 0);
    check("arst_seg_disp", seg2, 8'hFF);
    check("arst_player_disp", sp2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
